// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Refresh counter q selects the digit (top two bits).
// The display register is double-buffered through a shadow register and changes only at frame boundaries.
// Optional build macro: SSEG_LZ_BLANK_EN blanks leading-zero digits 3..1.
module sseg_scan_ctrl #(
  parameter int unsigned N = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic        ld,
  input  logic        en,
  output logic [3:0]  an,
  output logic [7:0]  sseg,
  output logic        frame_done
);

  localparam int unsigned DW  = 16;
  localparam int unsigned DPW = 4;

  logic [N-1:0]   q_q, q_d;
  logic [DW-1:0]  disp_q, disp_d, shadow_q, shadow_d;
  logic [DPW-1:0] disp_dp_q, disp_dp_d, shadow_dp_q, shadow_dp_d;
  logic           pending_q, pending_d;
  logic [3:0]     an_q, an_d;
  logic [7:0]     sseg_q, sseg_d;
  logic           frame_done_q, frame_done_d;

  logic           boundary;
  logic [1:0]     idx;
  logic [3:0]     nib;
  logic [6:0]     seg;

  // Hex to active-low abcdefg pattern
  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Counter advance and shadow/display double-buffer update
  always_comb begin
    boundary    = (q_q == {N{1'b1}});
    q_d         = q_q + N'(1);
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    if (boundary) begin
      pending_d = 1'b0;
      if (ld) begin
        // A load landing on the boundary bypasses the shadow straight to the display
        disp_d      = din;
        disp_dp_d   = dp_in;
        shadow_d    = din;
        shadow_dp_d = dp_in;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
      end
    end else if (ld) begin
      shadow_d    = din;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end
  end

  // Digit select, decode and anode drive for the next registered output
  always_comb begin
    idx = q_q[N-1:N-2];
    case (idx)
      2'd0:    nib = disp_q[3:0];
      2'd1:    nib = disp_q[7:4];
      2'd2:    nib = disp_q[11:8];
      default: nib = disp_q[15:12];
    endcase
    seg = seg_decode(nib);
`ifdef SSEG_LZ_BLANK_EN
    begin
      logic [3:0] lz;
      lz[3] = (disp_q[15:12] == 4'h0);
      lz[2] = lz[3] && (disp_q[11:8] == 4'h0);
      lz[1] = lz[2] && (disp_q[7:4] == 4'h0);
      lz[0] = 1'b0;
      if (lz[idx]) seg = 7'b1111111;
    end
`endif
    an_d         = en ? ~(4'b0001 << idx) : 4'b1111;
    sseg_d       = {~disp_dp_q[idx], seg};
    frame_done_d = boundary;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q          <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      an_q         <= 4'b1111;
      sseg_q       <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl with N=4 (4 cycles/digit, 16 cycles/frame).
// Honors SSEG_LZ_BLANK_EN for expected values on all-zero digits.
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        ld;
  logic        en;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  dp;
    logic [7:0]  exp [4];
  } vec_t;

  vec_t vecs [4];
  logic [7:0] prev [4];

  sseg_scan_ctrl #(.N(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .dp_in      (dp_in),
    .ld         (ld),
    .en         (en),
    .an         (an),
    .sseg       (sseg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance to the cycle after the edge that leaves the frame counter at p
  task automatic to_phase(input int p);
    do step(); while ((cyc % 16) != p);
  endtask

  // Expected segment byte for digit d of an all-zero display
  function automatic logic [7:0] zero_exp(input int d);
`ifdef SSEG_LZ_BLANK_EN
    return (d == 0) ? 8'h81 : 8'hFF;
`else
    return (d == 0) ? 8'h81 : 8'h81;
`endif
  endfunction

  function automatic logic [7:0] an_exp(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return {4'h0, ~(one << d)};
  endfunction

  // Check the four digits of the frame that starts at the next phase 1
  task automatic chk_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int d = 0; d < 4; d++) begin
      to_phase(1 + 4 * d);
      chk({name, "_seg"}, sseg, e[d]);
      chk({name, "_an"}, {4'h0, an}, an_exp(d));
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step();
      chk("rst_an", {4'h0, an}, 8'h0F);
      chk("rst_seg", sseg, 8'hFF);
      chk("rst_fd", {7'h0, frame_done}, 8'h00);
    end
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic load_at(input int p, input logic [15:0] d, input logic [3:0] dp);
    to_phase(p);
    ld = 1'b1; din = d; dp_in = dp;
    step();
    ld = 1'b0; din = 16'hFFFF; dp_in = 4'hF;
  endtask

  initial begin
    reset = 1'b1; ld = 1'b0; en = 1'b1; din = 16'h0; dp_in = 4'h0;

    // Hex digit nibbles: [3:0]=digit0 .. [15:12]=digit3; bit7 = ~dp
    vecs[0].din = 16'h12AF; vecs[0].dp = 4'b0100;
    vecs[0].exp[0] = 8'hB8; vecs[0].exp[1] = 8'h88; vecs[0].exp[2] = 8'h12; vecs[0].exp[3] = 8'hCF;
    vecs[1].din = 16'h3456; vecs[1].dp = 4'b0000;
    vecs[1].exp[0] = 8'hA0; vecs[1].exp[1] = 8'hA4; vecs[1].exp[2] = 8'hCC; vecs[1].exp[3] = 8'h86;
    vecs[2].din = 16'h789B; vecs[2].dp = 4'b1001;
    vecs[2].exp[0] = 8'h60; vecs[2].exp[1] = 8'h84; vecs[2].exp[2] = 8'h80; vecs[2].exp[3] = 8'h0F;
    vecs[3].din = 16'hCDE0; vecs[3].dp = 4'b0010;
    vecs[3].exp[0] = 8'h81; vecs[3].exp[1] = 8'h30; vecs[3].exp[2] = 8'hC2; vecs[3].exp[3] = 8'hB1;

    // Reset with ld asserted: load must be ignored
    ld = 1'b1; din = 16'h5555; dp_in = 4'hF;
    do_reset(3);
    ld = 1'b0;
    chk("first_post_rst_an", {4'h0, an}, 8'h0F);

    // Free-running scan of an all-zero display for three frames
    for (int k = 0; k < 48; k++) begin
      step();
      chk("scan_an", {4'h0, an}, an_exp(((cyc - 1) % 16) / 4));
      chk("scan_seg", sseg, zero_exp(((cyc - 1) % 16) / 4));
      chk("scan_fd", {7'h0, frame_done}, ((cyc % 16) == 0) ? 8'h01 : 8'h00);
    end

    // Table: mid-frame load, held until boundary, shown next frame
    for (int d = 0; d < 4; d++) prev[d] = zero_exp(d);
    for (int v = 0; v < 4; v++) begin
      load_at(5, vecs[v].din, vecs[v].dp);
      to_phase(9);
      chk("hold_before_boundary", sseg, prev[2]);
      to_phase(0);
      chk("boundary_fd", {7'h0, frame_done}, 8'h01);
      chk_frame("vec", vecs[v].exp[0], vecs[v].exp[1], vecs[v].exp[2], vecs[v].exp[3]);
      for (int d = 0; d < 4; d++) prev[d] = vecs[v].exp[d];
    end

    // Last load before the boundary wins
    load_at(3, 16'h1111, 4'h0);
    load_at(9, 16'h2222, 4'h0);
    to_phase(13);
    chk("last_wins_hold", sseg, 8'hB1);
    chk_frame("last_wins", 8'h92, 8'h92, 8'h92, 8'h92);

    // Load in the boundary cycle goes straight to the display, overriding pending data
    load_at(5, 16'h1111, 4'h0);
    load_at(15, 16'h8888, 4'h0);
    chk_frame("bnd_load", 8'h80, 8'h80, 8'h80, 8'h80);
    chk_frame("bnd_load_stable", 8'h80, 8'h80, 8'h80, 8'h80);

    // Mid-frame reset discards pending shadow data
    load_at(6, 16'h5555, 4'hF);
    to_phase(10);
    do_reset(2);
    chk_frame("rst_discard1", zero_exp(0), zero_exp(1), zero_exp(2), zero_exp(3));
    chk_frame("rst_discard2", zero_exp(0), zero_exp(1), zero_exp(2), zero_exp(3));

`ifdef SSEG_LZ_BLANK_EN
    load_at(5, 16'h0070, 4'h0);
    chk_frame("lz_0070", 8'h81, 8'h8F, 8'hFF, 8'hFF);
`endif

    // Display disabled: anodes off, segments keep scanning
    load_at(5, 16'h3456, 4'h0);
    to_phase(0);
    en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("en0_an", {4'h0, an}, 8'h0F);
      chk("en0_seg", sseg, vecs[1].exp[((cyc - 1) % 16) / 4]);
    end
    en = 1'b1;
    step();
    chk("en1_an", {4'h0, an}, an_exp(((cyc - 1) % 16) / 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
